// File: rtl/signal_pkg.sv
// Shared definitions for the run-length line signalling blocks.
//   sg_state_e : generator symbol state (IDLE, DATA, GAP)
//   MODE_PWM   : run followed by an inverted gap
//   MODE_OWT   : runs emitted back-to-back
package signal_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    GAP  = 2'd2
  } sg_state_e;

  localparam int MODE_PWM = 0;
  localparam int MODE_OWT = 1;

endpackage

// File: rtl/signal_gen.sv
// Run-length line signal generator.
// Accepts one data bit per i_vld/o_rdy handshake and emits it as HOLD identical
// line samples, one per i_tick. In PWM mode each run is followed by GAP inverted
// samples; in OWT mode runs are emitted back-to-back.
// Ports:
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_vld, i_vld_data   : data bit offered upstream
//   o_rdy               : bit accepted when i_vld & o_rdy (combinational)
//   i_tick              : sample strobe
//   o_vld, o_vld_data   : registered line sample valid / level
//   o_busy              : symbol in progress
module signal_gen
  import signal_pkg::*;
#(
  parameter int               CNT_W       = 10,
  parameter logic [CNT_W-1:0] HOLD        = CNT_W'(6),
  parameter logic [CNT_W-1:0] GAP         = CNT_W'(2),
  parameter int               MODE        = 1,
  parameter int               END_OF_LIST = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_vld,
  input  logic i_vld_data,
  output logic o_rdy,
  input  logic i_tick,
  output logic o_vld,
  output logic o_vld_data,
  output logic o_busy
);

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_LAST = HOLD - ONE;
  localparam logic [CNT_W-1:0] GAP_LAST  = GAP - ONE;

  // The local GAP parameter shadows the package state literal, so all state
  // literals are referenced with the package scope.
  signal_pkg::sg_state_e state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic                  bit_q, bit_n;
  logic                  vld_n, data_n;
  logic                  last_tick;
  logic                  hs;

  // The final tick of a symbol can accept the next bit so consecutive
  // symbols join without an idle sample.
  if (MODE == MODE_OWT) begin : g_owt
    assign last_tick = i_tick & (state == signal_pkg::DATA) & (cnt == HOLD_LAST);
  end else begin : g_pwm
    assign last_tick = i_tick & (state == signal_pkg::GAP) & (cnt == GAP_LAST);
  end

  // END_OF_LIST is only a parameter-list terminator.
  if (END_OF_LIST != 0) begin : g_eol
  end

  assign o_rdy  = (state == signal_pkg::IDLE) | last_tick;
  assign o_busy = (state != signal_pkg::IDLE);
  assign hs     = i_vld & o_rdy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= signal_pkg::IDLE;
      cnt        <= '0;
      bit_q      <= 1'b0;
      o_vld      <= 1'b0;
      o_vld_data <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_q      <= bit_n;
      o_vld      <= vld_n;
      o_vld_data <= data_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_q;
    vld_n   = 1'b0;
    data_n  = o_vld_data;
    unique case (state)
      signal_pkg::IDLE: begin
        // A tick in the accepting cycle produces no sample.
        if (hs) begin
          bit_n   = i_vld_data;
          cnt_n   = '0;
          state_n = signal_pkg::DATA;
        end
      end
      signal_pkg::DATA: begin
        if (i_tick) begin
          vld_n  = 1'b1;
          data_n = bit_q;
          cnt_n  = cnt + ONE;
          if (cnt == HOLD_LAST) begin
            cnt_n = '0;
            if (MODE == MODE_PWM) begin
              state_n = signal_pkg::GAP;
            end else if (hs) begin
              bit_n = i_vld_data;
            end else begin
              state_n = signal_pkg::IDLE;
            end
          end
        end
      end
      signal_pkg::GAP: begin
        if (i_tick) begin
          vld_n  = 1'b1;
          data_n = ~bit_q;
          cnt_n  = cnt + ONE;
          if (cnt == GAP_LAST) begin
            cnt_n = '0;
            if (hs) begin
              bit_n   = i_vld_data;
              state_n = signal_pkg::DATA;
            end else begin
              state_n = signal_pkg::IDLE;
            end
          end
        end
      end
      default: state_n = signal_pkg::IDLE;
    endcase
  end

`ifdef ASSERT_ON
  a_hold_min : assert property (@(posedge i_clk) HOLD != '0);
  a_gap_min  : assert property (@(posedge i_clk) (MODE != MODE_PWM) || (GAP != '0));
  a_hs_hold  : assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                (i_vld && !o_rdy) |=> (i_vld && $stable(i_vld_data)));
`endif

endmodule

// File: tb/tb_signal_gen.sv
module tb_signal_gen;
  import signal_pkg::*;

  localparam int CW   = 10;
  localparam int HOLD = 6;
  localparam int GAP  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic a_vld = 0, a_data = 0, a_tick = 0, a_rdy, a_ovld, a_odata, a_busy;
  logic p_vld = 0, p_data = 0, p_tick = 0, p_rdy, p_ovld, p_odata, p_busy;

  signal_gen #(.CNT_W(CW), .HOLD(CW'(HOLD)), .GAP(CW'(GAP)), .MODE(MODE_OWT)) u_owt (
    .i_clk(clk), .i_rst_n(rst_n), .i_vld(a_vld), .i_vld_data(a_data), .o_rdy(a_rdy),
    .i_tick(a_tick), .o_vld(a_ovld), .o_vld_data(a_odata), .o_busy(a_busy));

  signal_gen #(.CNT_W(CW), .HOLD(CW'(HOLD)), .GAP(CW'(GAP)), .MODE(MODE_PWM)) u_pwm (
    .i_clk(clk), .i_rst_n(rst_n), .i_vld(p_vld), .i_vld_data(p_data), .o_rdy(p_rdy),
    .i_tick(p_tick), .o_vld(p_ovld), .o_vld_data(p_odata), .o_busy(p_busy));

  int checks = 0;
  int failures = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endfunction

  // Scoreboard: every accepted bit expands into its symbol's sample list;
  // every emitted sample must match the head of that list.
  bit q_a[$];
  bit q_p[$];

  always @(negedge rst_n) begin
    q_a.delete();
    q_p.delete();
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_ovld) begin
        if (q_a.size() == 0) chk("owt_unexpected_sample", 1, 0);
        else chk("owt_sample", a_odata, q_a.pop_front());
      end
      if (p_ovld) begin
        if (q_p.size() == 0) chk("pwm_unexpected_sample", 1, 0);
        else chk("pwm_sample", p_odata, q_p.pop_front());
      end
      if (a_vld && a_rdy)
        for (int j = 0; j < HOLD; j++) q_a.push_back(a_data);
      if (p_vld && p_rdy) begin
        for (int j = 0; j < HOLD; j++) q_p.push_back(p_data);
        for (int j = 0; j < GAP; j++) q_p.push_back(!p_data);
      end
    end
  end

  task automatic drive(input bit pwm, input bit v, input bit d, input bit t);
    a_vld  = !pwm & v;  a_data = !pwm & d;  a_tick = !pwm & t;
    p_vld  = pwm & v;   p_data = pwm & d;   p_tick = pwm & t;
  endtask

  bit src[$];
  bit got[$];
  bit exp_q[$];

  // Streams src[] into one DUT with i_vld held, ticking every `period` cycles.
  task automatic run_stream(input bit pwm, input int period, input int exp_rdy_busy,
                            input string tag);
    int idx = 0, c_acc = -1, c_first = -1, last_t = -1, rdy_busy = 0, bad_sp = 0;
    int mism = 0, k;
    bit done = 0;
    bit ov, od, rd, bz, vv;
    got.delete();
    for (int c = 0; c < 400 && !done; c++) begin
      vv = idx < src.size();
      drive(pwm, vv, vv ? src[idx] : 1'b0, (c % period) == 0);
      @(negedge clk);
      ov = pwm ? p_ovld : a_ovld;
      od = pwm ? p_odata : a_odata;
      rd = pwm ? p_rdy : a_rdy;
      bz = pwm ? p_busy : a_busy;
      if (ov) begin
        got.push_back(od);
        if (last_t >= 0 && (c - last_t) != period) bad_sp++;
        if (c_first < 0) c_first = c;
        last_t = c;
      end
      if (rd && bz) rdy_busy++;
      if (vv && rd) begin
        if (idx == 0) c_acc = c;
        idx++;
      end
      if (idx == src.size() && !bz && c_first >= 0) done = 1;
      @(posedge clk); #1;
    end
    drive(pwm, 0, 0, 0);
    chk({tag, "_completed"}, done, 1);
    k = c_acc + 1;
    while ((k % period) != 0) k++;
    chk({tag, "_latency"}, c_first, k + 1);
    exp_q.delete();
    foreach (src[i]) begin
      for (int j = 0; j < HOLD; j++) exp_q.push_back(src[i]);
      if (pwm) for (int j = 0; j < GAP; j++) exp_q.push_back(!src[i]);
    end
    chk({tag, "_len"}, got.size(), exp_q.size());
    foreach (got[i]) if (i < exp_q.size() && got[i] != exp_q[i]) mism++;
    chk({tag, "_pattern"}, mism, 0);
    chk({tag, "_spacing"}, bad_sp, 0);
    chk({tag, "_rdy_in_symbol"}, rdy_busy, exp_rdy_busy);
  endtask

  typedef struct {
    bit vld; bit data; bit tick;
    bit e_ovld; bit e_odata; bit e_rdy; bit e_busy;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int n, extra;
    bit acc_a, acc_p;

    // OWT, single bit 1, tick every cycle; one row per cycle.
    tbl[0] = '{1, 1, 1, 0, 0, 1, 0};
    tbl[1] = '{0, 0, 1, 0, 0, 0, 1};
    tbl[2] = '{0, 0, 1, 1, 1, 0, 1};
    tbl[3] = '{0, 0, 1, 1, 1, 0, 1};
    tbl[4] = '{0, 0, 1, 1, 1, 0, 1};
    tbl[5] = '{0, 0, 1, 1, 1, 0, 1};
    tbl[6] = '{0, 0, 1, 1, 1, 1, 1};
    tbl[7] = '{0, 0, 1, 1, 1, 1, 0};
    tbl[8] = '{0, 0, 0, 0, 1, 1, 0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_owt_vld", a_ovld, 0);
    chk("rst_owt_data", a_odata, 0);
    chk("rst_owt_busy", a_busy, 0);
    chk("rst_owt_rdy", a_rdy, 1);
    chk("rst_pwm_vld", p_ovld, 0);
    chk("rst_pwm_data", p_odata, 0);
    chk("rst_pwm_busy", p_busy, 0);
    chk("rst_pwm_rdy", p_rdy, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      drive(0, tbl[i].vld, tbl[i].data, tbl[i].tick);
      @(negedge clk);
      chk($sformatf("t1_ovld_c%0d", i), a_ovld, tbl[i].e_ovld);
      if (tbl[i].e_ovld) chk($sformatf("t1_odata_c%0d", i), a_odata, tbl[i].e_odata);
      chk($sformatf("t1_rdy_c%0d", i), a_rdy, tbl[i].e_rdy);
      chk($sformatf("t1_busy_c%0d", i), a_busy, tbl[i].e_busy);
      @(posedge clk); #1;
    end

    src = '{1, 1, 0};
    run_stream(0, 1, 3, "owt_110");
    src = '{0, 0};
    run_stream(1, 1, 2, "pwm_00");
    src = '{1};
    run_stream(0, 3, 1, "owt_tick3");
    src = '{1};
    run_stream(1, 2, 1, "pwm_tick2");

    // Reset at the third sample of a run.
    n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      drive(0, c == 0, c == 0, 1);
      @(negedge clk);
      if (a_ovld) n++;
      if (n < 3) begin @(posedge clk); #1; end
    end
    chk("rst_mid_reached", n, 3);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_vld", a_ovld, 0);
    chk("rst_mid_busy", a_busy, 0);
    chk("rst_mid_rdy", a_rdy, 1);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      drive(0, 0, 0, 1);
      @(negedge clk);
      if (a_ovld || a_busy) extra++;
      @(posedge clk); #1;
    end
    chk("rst_mid_no_more_samples", extra, 0);
    src = '{1};
    run_stream(0, 1, 1, "post_rst");

    // Randomised traffic on both DUTs; the scoreboard checks every sample.
    for (int c = 0; c < 1500; c++) begin
      if (!a_vld && $urandom_range(0, 2) == 0) begin
        a_vld = 1'b1; a_data = 1'($urandom_range(0, 1));
      end
      if (!p_vld && $urandom_range(0, 2) == 0) begin
        p_vld = 1'b1; p_data = 1'($urandom_range(0, 1));
      end
      a_tick = 1'($urandom_range(0, 1));
      p_tick = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc_a = a_vld & a_rdy;
      acc_p = p_vld & p_rdy;
      @(posedge clk); #1;
      if (acc_a) a_vld = 1'b0;
      if (acc_p) p_vld = 1'b0;
    end
    // Bits still pending are finished before draining.
    for (int c = 0; c < 60 && (a_vld || p_vld); c++) begin
      a_tick = 1'b1; p_tick = 1'b1;
      @(negedge clk);
      acc_a = a_vld & a_rdy;
      acc_p = p_vld & p_rdy;
      @(posedge clk); #1;
      if (acc_a) a_vld = 1'b0;
      if (acc_p) p_vld = 1'b0;
    end
    chk("rand_all_accepted", a_vld | p_vld, 0);
    a_tick = 1'b1; p_tick = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    a_tick = 1'b0; p_tick = 1'b0;
    @(negedge clk);
    chk("rand_owt_drained", q_a.size(), 0);
    chk("rand_pwm_drained", q_p.size(), 0);
    chk("rand_owt_idle", a_busy, 0);
    chk("rand_pwm_idle", p_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/signal_gen.md
Name: signal_gen

Overview:
- Transmit-side counterpart of the run-length signal detector.
- Accepts one data bit per valid/ready handshake and serialises it as a run of HOLD identical line samples, one sample per sample strobe.
- In PWM mode each run is followed by a short inverted gap, so that a transition ends the symbol. In OWT mode runs are emitted back-to-back.
- Sits between the protocol framer and the pad/line driver. Its o_vld/o_vld_data pair is sample-for-sample compatible with a detector's i_vld/i_vld_data.

Parameters:
- CNT_W, 10: width of the sample counter.
- HOLD, CNT_W'(6): samples per data run. Must be >=1. Receiver DN_TH <= HOLD, and HOLD <= UP_TH (PWM) / HOLD < UP_TH (OWT).
- GAP, CNT_W'(2): inverted samples after each run, MODE 0 only. Must be >=1 and < receiver DN_TH.
- MODE, 1: 0 = pwm (run + gap); 1 = owt (run only).
- END_OF_LIST, 1: list terminator, unused.

Ports:
- i_clk, input, 1: clock.
- i_rst_n, input, 1: reset. One clock; reset is asynchronous and active-low.
- i_vld, input, 1: data bit valid.
- i_vld_data, input, 1: data bit value.
- o_rdy, output, 1: bit accepted when i_vld & o_rdy.
- i_tick, input, 1: sample strobe; one line sample per tick.
- o_vld, output, 1: line sample valid, registered.
- o_vld_data, output, 1: line sample level, registered.
- o_busy, output, 1: symbol in progress (state != IDLE).

Behaviour:
- Reset values: o_vld=0, o_vld_data=0, o_busy=0, state=IDLE, cnt=0, bit_q=0. o_rdy is combinational; it is 1 out of reset because the state is IDLE.
- States: IDLE, DATA, GAP (2-bit enum).
- o_rdy = (state==IDLE) | last_tick.
  - last_tick = i_tick & cnt==HOLD-1 & state==DATA & MODE==1
  - or i_tick & cnt==GAP-1 & state==GAP & MODE==0.
- IDLE:
  - On handshake: bit_q<=i_vld_data, cnt<=0, go to DATA.
  - Ticks in IDLE produce no sample (o_vld=0).
- DATA:
  - Each i_tick: o_vld<=1, o_vld_data<=bit_q, cnt<=cnt+1.
  - On the tick with cnt==HOLD-1 in MODE 0: cnt<=0, go to GAP.
  - On that tick in MODE 1: if a handshake occurs that cycle, bit_q<=new bit, cnt<=0, stay in DATA. Otherwise go to IDLE.
- GAP (MODE 0 only):
  - Each i_tick: o_vld<=1, o_vld_data<=~bit_q, cnt<=cnt+1.
  - On the tick with cnt==GAP-1: if a handshake occurs, load the new bit and go to DATA with cnt=0; else go to IDLE.
- Cycles without i_tick: o_vld<=0, o_vld_data holds, cnt and state hold.
- Latency: handshake at cycle T; the first sample appears on o_vld the cycle after the first i_tick strictly later than T. A tick in the same cycle as an IDLE handshake does not emit.
- Back-to-back: with i_vld held high and a tick every cycle, there are no idle samples.
  - MODE 1 emits exactly HOLD samples per bit.
  - MODE 0 emits HOLD+GAP samples per bit.
- Counter: cnt never exceeds max(HOLD,GAP)-1. There is no wrap-around within legal parameters.
- i_vld deasserted while o_rdy=0: ignored. The bit is not sampled until o_rdy.
- Reset asserted mid-symbol: all state clears immediately. The partial run is truncated and no further samples are emitted.
- Assertions (ASSERT_ON, synthesis off):
  - HOLD>=1.
  - MODE==0 -> GAP>=1.
  - i_vld stable-high with i_vld_data stable until accepted (checks the upstream handshake).

Decomposition:
- Package signal_pkg:
  - state enum sg_state_e {IDLE, DATA, GAP}.
  - Mode localparams MODE_PWM=0, MODE_OWT=1, shared with the detector.
- No sub-module. A single always_ff FSM/counter plus an output register is natural. MODE is selected by generate, in the same style as the detector.

Test Plan:
- MODE=1, HOLD=6, tick every cycle, single bit 1 -> o_vld high for 6 consecutive cycles with o_vld_data=1, then o_vld=0. o_rdy high again on the 6th tick.
- MODE=1, HOLD=6, stream 1,1,0 with i_vld held -> 18 contiguous samples (1×12, 0×6) with no o_vld gap. A detector (DN_TH=4, UP_TH=8, OWT) recovers 3 bits.
- MODE=0, HOLD=6, GAP=2, bits 0,0 -> pattern 000000 11 000000 11. A detector (DN_TH=4, UP_TH=8, PWM) outputs 0,0.
- i_tick every 3rd cycle, MODE=1, bit 1 -> 6 samples spaced 3 cycles apart. o_busy spans the whole symbol; o_rdy stays low except on the final tick.
- Reset pulse at the 3rd sample of a run -> o_vld=0 and o_busy=0 the same cycle, o_rdy=1. The next accepted bit emits a full 6-sample run.
- Handshake and i_tick in the same IDLE cycle -> no sample that cycle. The first sample follows the next tick.
